onehot_seq_checker: RTL and testbench

Receive-side checker for the 4-bit one-hot sequencer output stream (0000 → 0001 → 0010 → 0100 → 1000 → 0000 …). It decodes each sampled word to a phase index, acquires lock after a run of correct transitions, and flywheels through isolated errors. While locked, it flags and counts deviations from the expected sequence. It sits at the consumer end of the sequencer link and feeds status to control and debug logic.

---
 rtl/onehot_seq_checker.sv | 172 +++++++++++++++++
 tb/tb_onehot_seq_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_seq_checker.sv
// Receive-side checker for the 4-bit one-hot sequencer stream
// (0000 -> 0001 -> 0010 -> 0100 -> 1000 -> 0000 ...). It decodes each sample
// to a phase index, locks after a run of correct transitions, flywheels
// through isolated errors and counts deviations while locked.
module onehot_seq_checker #(
    parameter int LOCK_CNT   = 5,
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [3:0]       din,
    input  logic             clr_cnt,
    output logic [2:0]       phase,
    output logic             valid,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [2:0]       PH_ILLEGAL = 3'd7;
    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [2:0]       MISS_TGT   = 3'(MISS_LIMIT);
    localparam logic [ERR_W-1:0] CNT_MAX    = '1;

    logic [1:0]       state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic [2:0]       miss_q, miss_d;
    logic [2:0]       phase_q, phase_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [2:0] code;
    logic [2:0] exp_code;
    logic       hit;

    // Map a sequencer word to its phase index; anything not one-hot/zero is illegal.
    function automatic logic [2:0] decode(input logic [3:0] w);
        case (w)
            4'b0000: return 3'd0;
            4'b0001: return 3'd1;
            4'b0010: return 3'd2;
            4'b0100: return 3'd3;
            4'b1000: return 3'd4;
            default: return PH_ILLEGAL;
        endcase
    endfunction

    // Successor phase modulo 5; prev only ever holds 0..4.
    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    // Next-state logic: decode, compare against the predicted phase, and step the FSM.
    always_comb begin
        code     = decode(din);
        exp_code = next_phase(prev_q);
        hit      = (code == exp_code);

        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        miss_d  = miss_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;

        if (in_en) begin
            phase_d = code;
            valid_d = (code != PH_ILLEGAL);
            case (state_q)
                ST_SEARCH: begin
                    if (code != PH_ILLEGAL) begin
                        prev_d  = code;
                        good_d  = 4'd0;
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (code == PH_ILLEGAL) begin
                        good_d  = 4'd0;
                        miss_d  = 3'd0;
                        state_d = ST_SEARCH;
                    end else if (hit) begin
                        prev_d = code;
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_TGT) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        // Legal but out of order: restart the run from this code.
                        prev_d = code;
                        good_d = 4'd0;
                    end
                end
                default: begin
                    // LOCKED and HOLD share handling; miss_q is always 0 in LOCKED.
                    if (hit) begin
                        prev_d  = code;
                        miss_d  = 3'd0;
                        wrap_d  = (code == 3'd0);
                        state_d = ST_LOCKED;
                    end else begin
                        // Flywheel: advance the prediction as if the sample were correct.
                        err_d  = 1'b1;
                        prev_d = exp_code;
                        miss_d = miss_q + 3'd1;
                        if (miss_q + 3'd1 == MISS_TGT) begin
                            good_d  = 4'd0;
                            miss_d  = 3'd0;
                            state_d = ST_SEARCH;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            endcase
        end

        if (err_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SEARCH;
            prev_q  <= 3'd0;
            good_q  <= 4'd0;
            miss_q  <= 3'd0;
            phase_q <= 3'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phase   = phase_q;
    assign valid   = valid_q;
    assign locked  = (state_q == ST_LOCKED) || (state_q == ST_HOLD);
    assign err     = err_q;
    assign wrap    = wrap_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_onehot_seq_checker.sv
// Self-checking bench for onehot_seq_checker: directed scenarios plus random
// traffic, scored against a behavioural model through an expectation queue.
module tb_onehot_seq_checker;

    localparam int LOCK_CNT   = 5;
    localparam int MISS_LIMIT = 2;
    localparam int ERR_W      = 8;
    localparam int CNT_MAX    = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_en;
    logic [3:0]       din;
    logic             clr_cnt;
    logic [2:0]       phase;
    logic             valid;
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int phase;
        bit valid;
        bit locked;
        bit err;
        bit wrap;
        int cnt;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state
    int m_prev, m_run, m_miss, m_cnt, m_phase;
    bit m_lock, m_acq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onehot_seq_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .MISS_LIMIT(MISS_LIMIT),
        .ERR_W     (ERR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_en  (in_en),
        .din    (din),
        .clr_cnt(clr_cnt),
        .phase  (phase),
        .valid  (valid),
        .locked (locked),
        .err    (err),
        .wrap   (wrap),
        .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic int dec(input logic [3:0] w);
        if (w == 4'b0000) return 0;
        if ($countones(w) != 1) return 7;
        for (int i = 0; i < 4; i++) if (w[i]) return i + 1;
        return 7;
    endfunction

    function automatic logic [3:0] enc(input int p);
        return (p == 0) ? 4'b0000 : 4'(1 << (p - 1));
    endfunction

    function automatic logic [3:0] ideal();
        return enc((m_prev + 1) % 5);
    endfunction

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_phase = 0;
        m_lock = 0; m_acq = 0;
    endtask

    // One accepted clock edge of the reference behaviour; pushes the expected outputs.
    task automatic model_step(input bit en, input logic [3:0] w, input bit clr);
        exp_t e;
        int c, x;
        c = dec(w);
        x = (m_prev + 1) % 5;
        e.valid = 0; e.err = 0; e.wrap = 0;
        if (en) begin
            m_phase = c;
            e.valid = (c != 7);
            if (m_lock) begin
                if (c == x) begin
                    m_prev = c; m_miss = 0; e.wrap = (c == 0);
                end else begin
                    e.err = 1; m_prev = x; m_miss++;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (m_miss >= MISS_LIMIT) begin
                        m_lock = 0; m_acq = 0; m_run = 0; m_miss = 0;
                    end
                end
            end else if (m_acq) begin
                if (c == 7) begin
                    m_acq = 0; m_run = 0;
                end else if (c == x) begin
                    m_prev = c; m_run++;
                    if (m_run >= LOCK_CNT) begin
                        m_lock = 1; m_acq = 0; m_miss = 0;
                    end
                end else begin
                    m_prev = c; m_run = 0;
                end
            end else if (c != 7) begin
                m_acq = 1; m_prev = c; m_run = 0;
            end
            if (clr) m_cnt = 0;
        end
        e.phase = m_phase; e.locked = m_lock; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Drive one sample, let the edge take it, and return on the following falling edge.
    task automatic step(input bit en, input logic [3:0] w, input bit clr);
        in_en = en; din = w; clr_cnt = clr & en;
        @(posedge clk);
        model_step(en, w, clr & en);
        @(negedge clk);
    endtask

    // Monitor: every falling edge with a pending expectation compares the full output set.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("phase",   int'(phase),   e.phase);
            chk("valid",   int'(valid),   int'(e.valid));
            chk("locked",  int'(locked),  int'(e.locked));
            chk("err",     int'(err),     int'(e.err));
            chk("wrap",    int'(wrap),    int'(e.wrap));
            chk("err_cnt", int'(err_cnt), e.cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;
        int seq0[6];
        seq0 = '{0, 1, 2, 3, 4, 0};
        rst = 1'b1; in_en = 1'b0; din = 4'b0000; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_phase",  int'(phase),   0);
        chk("reset_valid",  int'(valid),   0);
        chk("reset_locked", int'(locked),  0);
        chk("reset_err",    int'(err),     0);
        chk("reset_wrap",   int'(wrap),    0);
        chk("reset_cnt",    int'(err_cnt), 0);
        rst = 1'b0;

        // Lock acquire: locked only after the sixth sample; the pre-lock wrap is silent.
        for (int i = 0; i < 6; i++) begin
            step(1, enc(seq0[i]), 0);
            chk("acq_phase", int'(phase), seq0[i]);
            chk("acq_wrap", int'(wrap), 0);
            if (i < 5) chk("acq_prelock", int'(locked), 0);
        end
        chk("acq_locked", int'(locked), 1);

        // Locked wrap: exactly one wrap pulse over a full cycle.
        wraps = 0;
        for (int p = 1; p <= 5; p++) begin
            step(1, enc(p % 5), 0);
            if (wrap) wraps++;
        end
        chk("wrap_count", wraps, 1);
        chk("wrap_cnt0", int'(err_cnt), 0);

        // Single glitch: expecting 0010, see 0011 then 0100.
        step(1, 4'b0001, 0);
        step(1, 4'b0011, 0);
        chk("glitch_err", int'(err), 1);
        chk("glitch_phase", int'(phase), 7);
        chk("glitch_cnt", int'(err_cnt), 1);
        chk("glitch_locked", int'(locked), 1);
        step(1, 4'b0100, 0);
        chk("glitch_recover_err", int'(err), 0);
        chk("glitch_recover_locked", int'(locked), 1);

        // Lock loss: clear the counter, then two wrong legal codes when 0001 is expected.
        step(1, 4'b1000, 1);
        step(1, 4'b0000, 0);
        chk("loss_pre_cnt", int'(err_cnt), 0);
        step(1, 4'b1000, 0);
        chk("loss_err1", int'(err), 1);
        chk("loss_locked1", int'(locked), 1);
        step(1, 4'b1000, 0);
        chk("loss_err2", int'(err), 1);
        chk("loss_cnt", int'(err_cnt), 2);
        chk("loss_locked2", int'(locked), 0);

        // Re-acquire: one seed sample then five fresh correct transitions.
        step(1, 4'b1000, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, enc(i), 0);
            chk("reacq_err", int'(err), 0);
            if (i < 4) chk("reacq_prelock", int'(locked), 0);
        end
        chk("reacq_locked", int'(locked), 1);

        // Gaps: idle cycles interleaved with a locked sequence.
        for (int i = 0; i < 10; i++) begin
            step(0, 4'($urandom_range(0, 15)), 0);
            chk("gap_err", int'(err), 0);
            chk("gap_valid", int'(valid), 0);
            step(1, ideal(), 0);
        end
        chk("gap_locked", int'(locked), 1);

        // Saturation: isolated glitches each followed by a correct sample.
        for (int i = 0; i < 300; i++) begin
            step(1, 4'b1111, 0);
            step(1, ideal(), 0);
        end
        chk("sat_cnt", int'(err_cnt), CNT_MAX);
        step(1, 4'b1111, 1);
        chk("clr_with_err", int'(err), 1);
        chk("clr_wins", int'(err_cnt), 0);
        step(1, ideal(), 0);

        // Random traffic, mostly on-sequence so lock is gained and lost repeatedly.
        for (int i = 0; i < 2500; i++) begin
            bit en;
            logic [3:0] w;
            en = ($urandom_range(0, 9) < 8);
            w  = ($urandom_range(0, 99) < 88) ? ideal() : 4'($urandom_range(0, 15));
            step(en, w, ($urandom_range(0, 49) == 0));
        end

        // Async reset mid-lock, asserted away from any clock edge.
        for (int i = 0; i < 20 && !m_lock; i++) step(1, ideal(), 0);
        chk("pre_rst_locked", int'(locked), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_phase",  int'(phase),   0);
        chk("arst_valid",  int'(valid),   0);
        chk("arst_locked", int'(locked),  0);
        chk("arst_err",    int'(err),     0);
        chk("arst_wrap",   int'(wrap),    0);
        chk("arst_cnt",    int'(err_cnt), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        step(1, 4'b0100, 0);
        chk("post_rst_phase", int'(phase), 3);
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_locked", int'(locked), 0);

        for (int i = 0; i < 600; i++) begin
            bit en;
            logic [3:0] w;
            en = ($urandom_range(0, 9) < 9);
            w  = ($urandom_range(0, 99) < 92) ? ideal() : 4'($urandom_range(0, 15));
            step(en, w, ($urandom_range(0, 99) == 0));
        end

        in_en = 1'b0; clr_cnt = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
